// File: rtl/bos_power_sequencer.sv
// bos_power_sequencer
//   Command-driven power sequencer for the BOS board supplies. It brings up
//   vcore, then vdigital, then the level-translator enable (functional), and
//   takes them down in reverse order. Each step waits a programmable settle
//   time. An external fault drops every rail at once. A one-byte status can
//   be read back through the have_msg/rdreq interface.
//
// Ports
//   clk, n_rst         clock, asynchronous active-low reset
//   master_data[7:0]   command byte, decoded while cmd_valid=1
//                      (0x01 up, 0x02 down, 0x03 clear fault, 0x04 status)
//   cmd_valid          one-cycle command strobe
//   fault_in           asynchronous fault input, active high
//   rdreq              readback request
//   have_msg, len      a status byte is waiting (len is 0 or 1)
//   slave_data[7:0]    status byte {fault, reject, bad_cmd, pwr_good, state[3:0]}
//   off_vcore_fpga, off_vdigital_fpga, functional
//                      rail enables (1 = on)
//   pwr_good, busy     in ON / in any UP_* or DOWN_* state
module bos_power_sequencer #(
  parameter int T_VCORE = 1000,
  parameter int T_VDIG  = 1000,
  parameter int T_FUNC  = 100,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] master_data,
  input  logic       cmd_valid,
  input  logic       fault_in,
  input  logic       rdreq,
  output logic       have_msg,
  output logic [7:0] slave_data,
  output logic [7:0] len,
  output logic       off_vcore_fpga,
  output logic       off_vdigital_fpga,
  output logic       functional,
  output logic       pwr_good,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_OFF        = 4'd0,
    S_UP_VCORE   = 4'd1,
    S_UP_VDIG    = 4'd2,
    S_UP_FUNC    = 4'd3,
    S_ON         = 4'd4,
    S_DOWN_FUNC  = 4'd5,
    S_DOWN_VDIG  = 4'd6,
    S_DOWN_VCORE = 4'd7,
    S_FAULT      = 4'd8
  } state_t;

  // The counter is loaded with T-1 so a wait state lasts exactly T cycles.
  localparam logic [CNT_W-1:0] LD_VCORE = CNT_W'(T_VCORE - 1);
  localparam logic [CNT_W-1:0] LD_VDIG  = CNT_W'(T_VDIG - 1);
  localparam logic [CNT_W-1:0] LD_FUNC  = CNT_W'(T_FUNC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_s1_q, fault_s1_d;
  logic             fault_s2_q, fault_s2_d;
  logic             fault_sticky_q, fault_sticky_d;
  logic             reject_q, reject_d;
  logic             bad_cmd_q, bad_cmd_d;
  logic             have_msg_q, have_msg_d;
  logic [7:0]       hold_q, hold_d;
  logic             vcore_q, vcore_d;
  logic             vdig_q, vdig_d;
  logic             func_q, func_d;
  logic             pwr_good_q, pwr_good_d;
  logic             busy_q, busy_d;

  logic cmd_up, cmd_down, cmd_clear, cmd_status, cmd_bad, set_reject, cnt_zero;

  always_comb begin
    cmd_up     = cmd_valid && (master_data == 8'h01);
    cmd_down   = cmd_valid && (master_data == 8'h02);
    cmd_clear  = cmd_valid && (master_data == 8'h03);
    cmd_status = cmd_valid && (master_data == 8'h04);
    cmd_bad    = cmd_valid && !(master_data inside {8'h01, 8'h02, 8'h03, 8'h04});
    cnt_zero   = (cnt_q == '0);

    fault_s1_d     = fault_in;
    fault_s2_d     = fault_s1_q;
    state_d        = state_q;
    cnt_d          = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    fault_sticky_d = fault_sticky_q;
    set_reject     = 1'b0;

    if (fault_s2_q) begin
      // Synchronised fault overrides any command arriving in the same cycle.
      state_d        = S_FAULT;
      fault_sticky_d = 1'b1;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (cmd_up) begin
            state_d = S_UP_VCORE;
            cnt_d   = LD_VCORE;
          end else if (cmd_down) begin
            set_reject = 1'b1;
          end
        end
        // A power-down during ramp-up reverses at the current level.
        S_UP_VCORE: begin
          if (cmd_down) begin
            state_d = S_DOWN_VCORE;
            cnt_d   = LD_VCORE;
          end else if (cnt_zero) begin
            state_d = S_UP_VDIG;
            cnt_d   = LD_VDIG;
          end
        end
        S_UP_VDIG: begin
          if (cmd_down) begin
            state_d = S_DOWN_VDIG;
            cnt_d   = LD_VDIG;
          end else if (cnt_zero) begin
            state_d = S_UP_FUNC;
            cnt_d   = LD_FUNC;
          end
        end
        S_UP_FUNC: begin
          if (cmd_down) begin
            state_d = S_DOWN_FUNC;
            cnt_d   = LD_FUNC;
          end else if (cnt_zero) begin
            state_d = S_ON;
          end
        end
        S_ON: begin
          if (cmd_down) begin
            state_d = S_DOWN_FUNC;
            cnt_d   = LD_FUNC;
          end else if (cmd_up) begin
            set_reject = 1'b1;
          end
        end
        S_DOWN_FUNC: begin
          set_reject = cmd_up || cmd_down;
          if (cnt_zero) begin
            state_d = S_DOWN_VDIG;
            cnt_d   = LD_VDIG;
          end
        end
        S_DOWN_VDIG: begin
          set_reject = cmd_up || cmd_down;
          if (cnt_zero) begin
            state_d = S_DOWN_VCORE;
            cnt_d   = LD_VCORE;
          end
        end
        S_DOWN_VCORE: begin
          set_reject = cmd_up || cmd_down;
          if (cnt_zero) state_d = S_OFF;
        end
        S_FAULT: begin
          set_reject = cmd_up || cmd_down;
          // Only reached with the synchronised fault low.
          if (cmd_clear) begin
            state_d        = S_OFF;
            fault_sticky_d = 1'b0;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Rails are decoded from the next state so they move with the state.
    vcore_d    = state_d inside {S_UP_VCORE, S_UP_VDIG, S_UP_FUNC, S_ON,
                                 S_DOWN_FUNC, S_DOWN_VDIG};
    vdig_d     = state_d inside {S_UP_VDIG, S_UP_FUNC, S_ON, S_DOWN_FUNC};
    func_d     = state_d inside {S_UP_FUNC, S_ON};
    pwr_good_d = (state_d == S_ON);
    busy_d     = state_d inside {S_UP_VCORE, S_UP_VDIG, S_UP_FUNC,
                                 S_DOWN_FUNC, S_DOWN_VDIG, S_DOWN_VCORE};

    // Reading status clears the sticky reject/bad_cmd flags; a new set wins.
    reject_d  = set_reject ? 1'b1 : (cmd_status ? 1'b0 : reject_q);
    bad_cmd_d = cmd_bad    ? 1'b1 : (cmd_status ? 1'b0 : bad_cmd_q);

    hold_d     = hold_q;
    have_msg_d = have_msg_q;
    if (cmd_status) begin
      hold_d     = {fault_sticky_q, reject_q, bad_cmd_q, pwr_good_q, state_q};
      have_msg_d = 1'b1;
    end else if (rdreq && have_msg_q) begin
      have_msg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_OFF;
      cnt_q          <= '0;
      fault_s1_q     <= 1'b0;
      fault_s2_q     <= 1'b0;
      fault_sticky_q <= 1'b0;
      reject_q       <= 1'b0;
      bad_cmd_q      <= 1'b0;
      have_msg_q     <= 1'b0;
      hold_q         <= '0;
      vcore_q        <= 1'b0;
      vdig_q         <= 1'b0;
      func_q         <= 1'b0;
      pwr_good_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fault_s1_q     <= fault_s1_d;
      fault_s2_q     <= fault_s2_d;
      fault_sticky_q <= fault_sticky_d;
      reject_q       <= reject_d;
      bad_cmd_q      <= bad_cmd_d;
      have_msg_q     <= have_msg_d;
      hold_q         <= hold_d;
      vcore_q        <= vcore_d;
      vdig_q         <= vdig_d;
      func_q         <= func_d;
      pwr_good_q     <= pwr_good_d;
      busy_q         <= busy_d;
    end
  end

  assign have_msg          = have_msg_q;
  assign len               = {7'd0, have_msg_q};
  assign slave_data        = have_msg_q ? hold_q : 8'h00;
  assign off_vcore_fpga    = vcore_q;
  assign off_vdigital_fpga = vdig_q;
  assign functional        = func_q;
  assign pwr_good          = pwr_good_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_bos_power_sequencer.sv
module tb_bos_power_sequencer;

  logic       clk;
  logic       n_rst;
  logic [7:0] master_data;
  logic       cmd_valid;
  logic       fault_in;
  logic       rdreq;
  logic       have_msg;
  logic [7:0] slave_data;
  logic [7:0] len;
  logic       off_vcore_fpga;
  logic       off_vdigital_fpga;
  logic       functional;
  logic       pwr_good;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bos_power_sequencer #(
    .T_VCORE(4), .T_VDIG(3), .T_FUNC(2), .CNT_W(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .master_data(master_data), .cmd_valid(cmd_valid),
    .fault_in(fault_in), .rdreq(rdreq), .have_msg(have_msg),
    .slave_data(slave_data), .len(len), .off_vcore_fpga(off_vcore_fpga),
    .off_vdigital_fpga(off_vdigital_fpga), .functional(functional),
    .pwr_good(pwr_good), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rails = {vcore, vdig, functional, pwr_good, busy}
  typedef struct {
    logic       cv;
    logic [7:0] data;
    logic       rd;
    logic [7:0] pre_rd;
    logic [4:0] rails;
    logic       hm;
    logic [7:0] sd;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [4:0] rails,
                          input logic hm, input logic [7:0] sd);
    chk({name, ".rails"},
        {3'd0, off_vcore_fpga, off_vdigital_fpga, functional, pwr_good, busy},
        {3'd0, rails});
    chk({name, ".have_msg"}, {7'd0, have_msg}, {7'd0, hm});
    chk({name, ".len"}, len, {7'd0, hm});
    chk({name, ".slave_data"}, slave_data, sd);
  endtask

  task automatic set_vec(input int i, input logic cv, input logic [7:0] data,
                         input logic rd, input logic [7:0] pre_rd,
                         input logic [4:0] rails, input logic hm, input logic [7:0] sd);
    vecs[i].cv = cv; vecs[i].data = data; vecs[i].rd = rd; vecs[i].pre_rd = pre_rd;
    vecs[i].rails = rails; vecs[i].hm = hm; vecs[i].sd = sd;
  endtask

  task automatic cmd(input logic [7:0] c);
    cmd_valid = 1'b1;
    master_data = c;
    tick();
    cmd_valid = 1'b0;
    master_data = 8'h00;
  endtask

  task automatic read_status(input string name, input logic [7:0] exp);
    cmd(8'h04);
    chk({name, ".hm"}, {7'd0, have_msg}, 8'h01);
    chk({name, ".byte"}, slave_data, exp);
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk({name, ".drained"}, {7'd0, have_msg}, 8'h00);
    $display("status %s: 0x%02h (expected 0x%02h)", name, slave_data, exp);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #7;
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    n_rst = 1'b0; master_data = 8'h00; cmd_valid = 1'b0; fault_in = 1'b0; rdreq = 1'b0;

    // Power-up, in-ON command checks, power-down and readback.
    set_vec(0,  1, 8'h01, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(1,  0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(2,  0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(3,  0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(4,  0, 8'h00, 0, 8'h00, 5'b11001, 0, 8'h00);
    set_vec(5,  0, 8'h00, 0, 8'h00, 5'b11001, 0, 8'h00);
    set_vec(6,  0, 8'h00, 0, 8'h00, 5'b11001, 0, 8'h00);
    set_vec(7,  0, 8'h00, 0, 8'h00, 5'b11101, 0, 8'h00);
    set_vec(8,  0, 8'h00, 0, 8'h00, 5'b11101, 0, 8'h00);
    set_vec(9,  0, 8'h00, 0, 8'h00, 5'b11110, 0, 8'h00);
    set_vec(10, 1, 8'h55, 0, 8'h00, 5'b11110, 0, 8'h00);
    set_vec(11, 1, 8'h01, 0, 8'h00, 5'b11110, 0, 8'h00);
    set_vec(12, 1, 8'h04, 0, 8'h00, 5'b11110, 1, 8'h74);
    set_vec(13, 1, 8'h04, 1, 8'h74, 5'b11110, 1, 8'h14);
    set_vec(14, 0, 8'h00, 1, 8'h14, 5'b11110, 0, 8'h00);
    set_vec(15, 1, 8'h02, 0, 8'h00, 5'b11001, 0, 8'h00);
    set_vec(16, 0, 8'h00, 0, 8'h00, 5'b11001, 0, 8'h00);
    set_vec(17, 0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(18, 0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(19, 0, 8'h00, 0, 8'h00, 5'b10001, 0, 8'h00);
    set_vec(20, 0, 8'h00, 0, 8'h00, 5'b00001, 0, 8'h00);
    set_vec(21, 0, 8'h00, 0, 8'h00, 5'b00001, 0, 8'h00);
    set_vec(22, 0, 8'h00, 0, 8'h00, 5'b00001, 0, 8'h00);
    set_vec(23, 0, 8'h00, 0, 8'h00, 5'b00001, 0, 8'h00);
    set_vec(24, 0, 8'h00, 0, 8'h00, 5'b00000, 0, 8'h00);
    set_vec(25, 1, 8'h04, 0, 8'h00, 5'b00000, 1, 8'h00);
    set_vec(26, 0, 8'h00, 1, 8'h00, 5'b00000, 0, 8'h00);
    set_vec(27, 1, 8'h02, 0, 8'h00, 5'b00000, 0, 8'h00);
    set_vec(28, 1, 8'h04, 0, 8'h00, 5'b00000, 1, 8'h40);
    set_vec(29, 0, 8'h00, 1, 8'h40, 5'b00000, 0, 8'h00);

    // Reset state, held and after release.
    tick();
    chk_outs("reset_held", 5'b00000, 1'b0, 8'h00);
    n_rst = 1'b1;
    tick();
    chk_outs("reset_rel", 5'b00000, 1'b0, 8'h00);

    for (int i = 0; i < NV; i++) begin
      cmd_valid = vecs[i].cv;
      master_data = vecs[i].data;
      rdreq = vecs[i].rd;
      #1;
      if (vecs[i].rd) chk($sformatf("v%0d.rd_byte", i), slave_data, vecs[i].pre_rd);
      tick();
      cmd_valid = 1'b0; master_data = 8'h00; rdreq = 1'b0;
      chk_outs($sformatf("v%0d", i), vecs[i].rails, vecs[i].hm, vecs[i].sd);
      $display("vec %0d: cmd=%0b/0x%02h rd=%0b -> rails=%05b hm=%0b sd=0x%02h",
               i, vecs[i].cv, vecs[i].data, vecs[i].rd,
               {off_vcore_fpga, off_vdigital_fpga, functional, pwr_good, busy},
               have_msg, slave_data);
    end

    // Power-down while in UP_VDIG reverses at that level.
    do_reset();
    cmd(8'h01);                       // edge 1: UP_VCORE
    repeat (4) tick();                // edge 5: UP_VDIG
    chk_outs("rev.up_vdig", 5'b11001, 1'b0, 8'h00);
    tick();                           // edge 6
    cmd(8'h02);                       // edge 7: DOWN_VDIG
    chk_outs("rev.down_vdig", 5'b10001, 1'b0, 8'h00);
    repeat (2) tick();
    chk_outs("rev.vdig_hold", 5'b10001, 1'b0, 8'h00);
    tick();                           // T_VDIG after entry: DOWN_VCORE
    chk_outs("rev.down_vcore", 5'b00001, 1'b0, 8'h00);
    repeat (3) tick();
    chk_outs("rev.vcore_hold", 5'b00001, 1'b0, 8'h00);
    tick();                           // T_VCORE after entry: OFF
    chk_outs("rev.off", 5'b00000, 1'b0, 8'h00);
    $display("reverse-from-UP_VDIG sequence done");

    // Fault in ON, blocked clear, then clear after fault drops.
    cmd(8'h01);
    repeat (9) tick();
    chk_outs("flt.on", 5'b11110, 1'b0, 8'h00);
    fault_in = 1'b1;
    tick();
    chk_outs("flt.edge1", 5'b11110, 1'b0, 8'h00);
    tick();
    chk_outs("flt.edge2", 5'b11110, 1'b0, 8'h00);
    tick();
    chk_outs("flt.edge3", 5'b00000, 1'b0, 8'h00);
    read_status("flt.status", 8'h88);
    cmd(8'h03);
    read_status("flt.clear_blocked", 8'h88);
    fault_in = 1'b0;
    repeat (3) tick();
    chk_outs("flt.still_fault", 5'b00000, 1'b0, 8'h00);
    cmd(8'h03);
    read_status("flt.cleared", 8'h00);
    cmd(8'h01);
    chk_outs("flt.up_again", 5'b10001, 1'b0, 8'h00);

    // Asynchronous reset in the middle of UP_VDIG.
    do_reset();
    cmd(8'h01);
    repeat (4) tick();                // UP_VDIG
    cmd(8'h04);                       // leave a message pending
    chk_outs("rst.pre", 5'b11001, 1'b1, 8'h02);
    #2;
    n_rst = 1'b0;
    #1;
    chk_outs("rst.async", 5'b00000, 1'b0, 8'h00);
    tick();
    n_rst = 1'b1;
    tick();
    chk_outs("rst.after", 5'b00000, 1'b0, 8'h00);
    read_status("rst.status", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
